// File: rtl/rvh_l1d_victim_ctrl_pkg.sv
// =============================================================================
//  Module   : rvh_l1d_victim_ctrl_pkg
//  Brief    : Geometry constants, FSM state codes and address helper for the
//             L1D refill victim controller.
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

package rvh_l1d_victim_ctrl_pkg;

   localparam int ENTRY_NUM = 32;
   localparam int ENTRY_IDX = $clog2(ENTRY_NUM);
   localparam int WAY_NUM   = 4;
   localparam int WAY_IDX   = $clog2(WAY_NUM);
   localparam int TAG_W     = 28;
   localparam int OFFSET_W  = 6;
   localparam int PADDR_W   = TAG_W + ENTRY_IDX + OFFSET_W;
   localparam int LINE_W    = 512;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEL  = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_INST = 3'd5;

   // Line-aligned physical address of a cached line.
   function automatic logic [PADDR_W-1:0] line_paddr(input logic [TAG_W-1:0]     tag,
                                                     input logic [ENTRY_IDX-1:0] set);
      return {tag, set, {OFFSET_W{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rvh_l1d_victim_ctrl_if.sv
// =============================================================================
//  Module   : rvh_l1d_victim_ctrl_if
//  Brief    : Refill, PLRU, victim-read, writeback and install signals of the
//             victim controller; master = controller, slave = surroundings.
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

interface rvh_l1d_victim_ctrl_if;
   import rvh_l1d_victim_ctrl_pkg::*;

   logic                 refill_vld;
   logic                 refill_rdy;
   logic [ENTRY_IDX-1:0] refill_set;
   logic [TAG_W-1:0]     refill_tag;
   logic [LINE_W-1:0]    refill_line;
   logic                 hit_upd_en;

   logic                 plru_rd_en;
   logic [ENTRY_IDX-1:0] plru_rd_idx;
   logic [WAY_IDX-1:0]   plru_rd_way;

   logic                 vic_rd_en;
   logic [ENTRY_IDX-1:0] vic_rd_set;
   logic [WAY_IDX-1:0]   vic_rd_way;
   logic                 vic_valid;
   logic                 vic_dirty;
   logic [TAG_W-1:0]     vic_tag;
   logic [LINE_W-1:0]    vic_line;

   logic                 wb_vld;
   logic                 wb_rdy;
   logic [PADDR_W-1:0]   wb_paddr;
   logic [LINE_W-1:0]    wb_line;

   logic                 inst_en;
   logic [ENTRY_IDX-1:0] inst_set;
   logic [WAY_IDX-1:0]   inst_way;
   logic [TAG_W-1:0]     inst_tag;
   logic [LINE_W-1:0]    inst_line;

   logic                 busy;
   logic [ENTRY_IDX-1:0] busy_set;

   modport master (
      input  refill_vld, refill_set, refill_tag, refill_line, hit_upd_en,
             plru_rd_way, vic_valid, vic_dirty, vic_tag, vic_line, wb_rdy,
      output refill_rdy, plru_rd_en, plru_rd_idx, vic_rd_en, vic_rd_set, vic_rd_way,
             wb_vld, wb_paddr, wb_line, inst_en, inst_set, inst_way, inst_tag,
             inst_line, busy, busy_set
   );

   modport slave (
      output refill_vld, refill_set, refill_tag, refill_line, hit_upd_en,
             plru_rd_way, vic_valid, vic_dirty, vic_tag, vic_line, wb_rdy,
      input  refill_rdy, plru_rd_en, plru_rd_idx, vic_rd_en, vic_rd_set, vic_rd_way,
             wb_vld, wb_paddr, wb_line, inst_en, inst_set, inst_way, inst_tag,
             inst_line, busy, busy_set
   );

endinterface

`default_nettype wire

// File: rtl/rvh_l1d_victim_ctrl.sv
// =============================================================================
//  Module   : rvh_l1d_victim_ctrl
//  Brief    : One-at-a-time L1D refill: pick PLRU victim, read it, write it back
//             if valid&dirty, then install the refilled line.
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module rvh_l1d_victim_ctrl
   import rvh_l1d_victim_ctrl_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   rvh_l1d_victim_ctrl_if.master        bus
);

   logic [2:0]           r_state;
   logic [ENTRY_IDX-1:0] r_set;
   logic [TAG_W-1:0]     r_tag;
   logic [LINE_W-1:0]    r_line;
   logic [WAY_IDX-1:0]   r_way;
   logic [TAG_W-1:0]     r_vic_tag;
   logic [LINE_W-1:0]    r_vic_line;

   logic w_accept;
   logic w_plru_fire;
   logic w_in_rd;
   logic w_in_wb;
   logic w_in_inst;
   logic w_busy;

   assign w_accept    = bus.refill_vld & bus.refill_rdy;
   // The PLRU gives the hit update priority, so the refill read waits it out.
   assign w_plru_fire = (r_state == S_SEL) & ~bus.hit_upd_en;
   assign w_in_rd     = (r_state == S_RD);
   assign w_in_wb     = (r_state == S_WB);
   assign w_in_inst   = (r_state == S_INST);
   assign w_busy      = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_set      <= '0;
         r_tag      <= '0;
         r_line     <= '0;
         r_way      <= '0;
         r_vic_tag  <= '0;
         r_vic_line <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_set   <= bus.refill_set;
               r_tag   <= bus.refill_tag;
               r_line  <= bus.refill_line;
               r_state <= S_SEL;
            end
            S_SEL: if (w_plru_fire) begin
               r_way   <= bus.plru_rd_way;
               r_state <= S_RD;
            end
            S_RD: r_state <= S_CHK;
            S_CHK: if (bus.vic_valid & bus.vic_dirty) begin
               r_vic_tag  <= bus.vic_tag;
               r_vic_line <= bus.vic_line;
               r_state    <= S_WB;
            end else begin
               r_state <= S_INST;
            end
            S_WB:    if (bus.wb_rdy) r_state <= S_INST;
            S_INST:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Payload buses are zero whenever their strobe is low.
   assign bus.refill_rdy  = (r_state == S_IDLE) & ~rst;
   assign bus.plru_rd_en  = w_plru_fire;
   assign bus.plru_rd_idx = w_plru_fire ? r_set : '0;
   assign bus.vic_rd_en   = w_in_rd;
   assign bus.vic_rd_set  = w_in_rd ? r_set : '0;
   assign bus.vic_rd_way  = w_in_rd ? r_way : '0;
   assign bus.wb_vld      = w_in_wb;
   assign bus.wb_paddr    = w_in_wb ? line_paddr(r_vic_tag, r_set) : '0;
   assign bus.wb_line     = w_in_wb ? r_vic_line : '0;
   assign bus.inst_en     = w_in_inst;
   assign bus.inst_set    = w_in_inst ? r_set : '0;
   assign bus.inst_way    = w_in_inst ? r_way : '0;
   assign bus.inst_tag    = w_in_inst ? r_tag : '0;
   assign bus.inst_line   = w_in_inst ? r_line : '0;
   assign bus.busy        = w_busy;
   assign bus.busy_set    = w_busy ? r_set : '0;

endmodule

`default_nettype wire

// File: tb/tb_rvh_l1d_victim_ctrl.sv
// =============================================================================
//  Module   : tb_rvh_l1d_victim_ctrl
//  Brief    : Directed scenarios plus random traffic against a refill-level
//             reference model of the victim controller.
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_rvh_l1d_victim_ctrl;
   import rvh_l1d_victim_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rvh_l1d_victim_ctrl_if bus ();

   rvh_l1d_victim_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic cmp(input string name, input logic [575:0] act, input logic [575:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [LINE_W-1:0] rline();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Reference model: one refill record; phase counts cycles after the PLRU read
   // (-1 while the read is still pending).
   bit                   armed = 0;
   bit                   m_busy = 0;
   int                   m_ph = 0;
   logic [ENTRY_IDX-1:0] m_set;
   logic [TAG_W-1:0]     m_tag;
   logic [LINE_W-1:0]    m_line;
   logic [WAY_IDX-1:0]   m_way;
   bit                   m_wb, m_wb_done;
   logic [TAG_W-1:0]     m_wtag;
   logic [LINE_W-1:0]    m_wline;

   always @(negedge clk) begin : p_model
      bit e_rdy, e_plru, e_vrd, e_wb, e_inst;
      if (armed) begin
         e_rdy  = !m_busy && !rst;
         e_plru = m_busy && m_ph < 0 && !bus.hit_upd_en;
         e_vrd  = m_busy && m_ph == 1;
         e_wb   = m_busy && m_ph >= 3 && m_wb && !m_wb_done;
         e_inst = m_busy && m_ph >= 3 && !(m_wb && !m_wb_done);
         cmp("refill_rdy", bus.refill_rdy, e_rdy);
         cmp("plru_rd_en", bus.plru_rd_en, e_plru);
         cmp("vic_rd_en", bus.vic_rd_en, e_vrd);
         cmp("wb_vld", bus.wb_vld, e_wb);
         cmp("inst_en", bus.inst_en, e_inst);
         cmp("busy", bus.busy, m_busy);
         cmp("busy_set", bus.busy_set, m_busy ? m_set : '0);
         if (e_plru) cmp("plru_rd_idx", bus.plru_rd_idx, m_set);
         if (e_vrd) begin
            cmp("vic_rd_set", bus.vic_rd_set, m_set);
            cmp("vic_rd_way", bus.vic_rd_way, m_way);
         end
         if (e_wb) begin
            cmp("wb_paddr", bus.wb_paddr, {m_wtag, m_set, 6'd0});
            cmp("wb_line", bus.wb_line, m_wline);
         end
         if (e_inst) begin
            cmp("inst_set", bus.inst_set, m_set);
            cmp("inst_way", bus.inst_way, m_way);
            cmp("inst_tag", bus.inst_tag, m_tag);
            cmp("inst_line", bus.inst_line, m_line);
         end
      end
      if (rst) begin
         armed  = 1;
         m_busy = 0;
         m_ph   = 0;
      end else if (armed) begin
         if (!m_busy) begin
            if (bus.refill_vld) begin
               m_busy    = 1;
               m_ph      = -1;
               m_set     = bus.refill_set;
               m_tag     = bus.refill_tag;
               m_line    = bus.refill_line;
               m_wb      = 0;
               m_wb_done = 0;
            end
         end else if (m_ph < 0) begin
            if (!bus.hit_upd_en) begin
               m_way = bus.plru_rd_way;
               m_ph  = 1;
            end
         end else if (m_ph == 1) begin
            m_ph = 2;
         end else if (m_ph == 2) begin
            m_wb    = bus.vic_valid && bus.vic_dirty;
            m_wtag  = bus.vic_tag;
            m_wline = bus.vic_line;
            m_ph    = 3;
         end else if (m_wb && !m_wb_done) begin
            if (bus.wb_rdy) m_wb_done = 1;
         end else begin
            m_busy = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.refill_vld  = 0;
      bus.hit_upd_en  = 0;
      bus.wb_rdy      = 0;
      bus.vic_valid   = 0;
      bus.vic_dirty   = 0;
      repeat (3) step();
   endtask

   task automatic refill(input logic [ENTRY_IDX-1:0] s, input logic [TAG_W-1:0] t);
      bus.refill_vld  = 1;
      bus.refill_set  = s;
      bus.refill_tag  = t;
      bus.refill_line = rline();
   endtask

   initial begin
      rst             = 1;
      bus.refill_vld  = 0;
      bus.refill_set  = '0;
      bus.refill_tag  = '0;
      bus.refill_line = '0;
      bus.hit_upd_en  = 0;
      bus.plru_rd_way = '0;
      bus.vic_valid   = 0;
      bus.vic_dirty   = 0;
      bus.vic_tag     = '0;
      bus.vic_line    = '0;
      bus.wb_rdy      = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("rst_refill_rdy", bus.refill_rdy, 1'b0);
      cmp("rst_busy", bus.busy, 1'b0);
      step();
      rst = 0;
      quiet();

      // Clean victim: install four cycles after the handshake.
      refill(5, 28'h123);
      bus.plru_rd_way = 2;
      bus.vic_line    = rline();
      @(negedge clk) cmp("clean_rdy_T", bus.refill_rdy, 1'b1);
      step(); bus.refill_vld = 0;
      @(negedge clk) cmp("clean_plru_T1", bus.plru_rd_en, 1'b1);
      cmp("clean_plru_idx", bus.plru_rd_idx, 5'd5);
      step(); bus.plru_rd_way = 0;
      @(negedge clk) cmp("clean_vrd_T2", bus.vic_rd_en, 1'b1);
      cmp("clean_vrd_way", bus.vic_rd_way, 2'd2);
      step();
      step();
      @(negedge clk) cmp("clean_inst_T4", bus.inst_en, 1'b1);
      cmp("clean_inst_way", bus.inst_way, 2'd2);
      cmp("clean_inst_tag", bus.inst_tag, 28'h123);
      cmp("clean_no_wb", bus.wb_vld, 1'b0);
      quiet();

      // Dirty victim with writeback back-pressure.
      refill(5, 28'h55);
      bus.plru_rd_way = 1;
      bus.vic_valid   = 1;
      bus.vic_dirty   = 1;
      bus.vic_tag     = 28'hABC;
      bus.vic_line    = rline();
      step(); bus.refill_vld = 0;
      repeat (3) step();
      @(negedge clk) cmp("dirty_wb_T4", bus.wb_vld, 1'b1);
      cmp("dirty_paddr", bus.wb_paddr, 39'h55E140);
      step();
      @(negedge clk) cmp("dirty_wb_T5", bus.wb_vld, 1'b1);
      step();
      @(negedge clk) cmp("dirty_wb_T6", bus.wb_vld, 1'b1);
      step(); bus.wb_rdy = 1;
      @(negedge clk) cmp("dirty_wb_T7", bus.wb_vld, 1'b1);
      step(); bus.wb_rdy = 0;
      @(negedge clk) cmp("dirty_inst_T8", bus.inst_en, 1'b1);
      cmp("dirty_inst_tag", bus.inst_tag, 28'h55);
      cmp("dirty_wb_done", bus.wb_vld, 1'b0);
      quiet();

      // Hit update collides with the PLRU read for two cycles.
      refill(9, 28'h7);
      bus.plru_rd_way = 3;
      step(); bus.refill_vld = 0; bus.hit_upd_en = 1;
      @(negedge clk) cmp("hit_defer1", bus.plru_rd_en, 1'b0);
      step();
      @(negedge clk) cmp("hit_defer2", bus.plru_rd_en, 1'b0);
      step(); bus.hit_upd_en = 0;
      @(negedge clk) cmp("hit_fire", bus.plru_rd_en, 1'b1);
      cmp("hit_idx", bus.plru_rd_idx, 5'd9);
      step();
      @(negedge clk) cmp("hit_single", bus.plru_rd_en, 1'b0);
      step(); step();
      @(negedge clk) cmp("hit_inst", bus.inst_en, 1'b1);
      cmp("hit_inst_way", bus.inst_way, 2'd3);
      quiet();

      // Back-to-back refills with refill_vld held high.
      refill(3, 28'h33);
      step(); bus.refill_set = 4; bus.refill_tag = 28'h44;
      repeat (3) step();
      @(negedge clk) cmp("b2b_inst", bus.inst_en, 1'b1);
      cmp("b2b_busy_set", bus.busy_set, 5'd3);
      step();
      @(negedge clk) cmp("b2b_rdy", bus.refill_rdy, 1'b1);
      cmp("b2b_idle_set", bus.busy_set, 5'd0);
      step(); bus.refill_vld = 0;
      @(negedge clk) cmp("b2b_busy2", bus.busy, 1'b1);
      cmp("b2b_busy_set2", bus.busy_set, 5'd4);
      repeat (4) step();
      quiet();

      // Reset while a writeback is pending drops the refill.
      refill(6, 28'h66);
      bus.vic_valid = 1;
      bus.vic_dirty = 1;
      bus.vic_tag   = 28'h1;
      step(); bus.refill_vld = 0;
      repeat (3) step();
      @(negedge clk) cmp("rstwb_wb", bus.wb_vld, 1'b1);
      step(); rst = 1;
      @(negedge clk) cmp("rstwb_rdy_in_rst", bus.refill_rdy, 1'b0);
      step(); rst = 0;
      @(negedge clk) cmp("rstwb_wb_gone", bus.wb_vld, 1'b0);
      cmp("rstwb_no_inst", bus.inst_en, 1'b0);
      cmp("rstwb_rdy", bus.refill_rdy, 1'b1);
      quiet();

      // Valid but clean victim: no writeback.
      refill(12, 28'hF00);
      bus.vic_valid = 1;
      bus.vic_dirty = 0;
      step(); bus.refill_vld = 0;
      repeat (3) step();
      @(negedge clk) cmp("vclean_inst", bus.inst_en, 1'b1);
      cmp("vclean_no_wb", bus.wb_vld, 1'b0);
      quiet();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         bus.refill_vld  = ($urandom % 3) != 0;
         bus.refill_set  = ENTRY_IDX'($urandom);
         bus.refill_tag  = TAG_W'($urandom);
         bus.refill_line = rline();
         bus.hit_upd_en  = ($urandom % 4) == 0;
         bus.plru_rd_way = WAY_IDX'($urandom);
         bus.vic_valid   = $urandom % 2;
         bus.vic_dirty   = $urandom % 2;
         bus.vic_tag     = TAG_W'($urandom);
         bus.vic_line    = rline();
         bus.wb_rdy      = $urandom % 2;
         rst             = ($urandom % 150) == 0;
         step();
      end
      rst = 0;
      quiet();
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
